// File: rtl/gary_arbiter.sv
// Gary chip-bus controller: address decode, CPU/DMA slot arbitration, overlays, CIA E-clock sync.
// Optional IDE/Gayle decode is built when GARY_IDE_EN is defined.
module gary_arbiter #(
  parameter int CHIP_BANKS = 4,
  parameter int SLOW_BANKS = 3,
  parameter int MAX_STALL  = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cck,
  input  logic                  e,
  input  logic [23:12]          cpuaddress,
  input  logic [20:19]          dmaaddress,
  input  logic                  cpurd,
  input  logic                  cpuhwr,
  input  logic                  cpulwr,
  input  logic                  dma,
  input  logic                  dmawr,
  input  logic                  dmapri,
  input  logic                  ovl,
  input  logic                  boot,
  output logic                  dbr,
  output logic                  rd,
  output logic                  hwr,
  output logic                  lwr,
  output logic [CHIP_BANKS-1:0] selchip,
  output logic [SLOW_BANKS-1:0] selslow,
  output logic                  selreg,
  output logic                  selciaa,
  output logic                  selciab,
  output logic                  selkick,
  output logic                  selboot,
  output logic                  selide,
  output logic                  selgayle,
  output logic [1:0]            dbg_state,
  output logic [7:0]            dbg_stall
);

  localparam int SW = (MAX_STALL < 2) ? 1 : $clog2(MAX_STALL + 1);
  localparam logic [SW-1:0] STALL_MAX = SW'(MAX_STALL);
  localparam logic [1:0] CHIP_MASK = 2'(CHIP_BANKS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SYNC = 2'd1,
    S_END  = 2'd2
  } cia_state_t;

  cia_state_t    state;
  logic [SW-1:0] stall_cnt;
  logic          acc;
  logic          cia;
  logic          chipreg;
  logic          force_slot;
  logic          cia_wait;
  logic          chip_en;
  logic [1:0]    chip_idx;
  logic          slow_en;

  assign acc     = cpurd | cpuhwr | cpulwr;
  assign cia     = selciaa | selciab;
  assign chipreg = (cpuaddress[23:21] == 3'b000) | (cpuaddress[23:21] == 3'b110);

  // Region decode; DMA owns the bus whenever dma is high, so every CPU select is masked then.
  always_comb begin
    chip_en  = 1'b0;
    chip_idx = 2'b00;
    slow_en  = 1'b0;
    selreg   = 1'b0;
    selciaa  = 1'b0;
    selciab  = 1'b0;
    selkick  = 1'b0;
    selboot  = 1'b0;
    selide   = 1'b0;
    selgayle = 1'b0;
    if (dma) begin
      chip_en  = 1'b1;
      chip_idx = dmaaddress & CHIP_MASK;
    end else begin
      if (cpuaddress[23:19] == 5'b11111)
        selkick = 1'b1;
      if (cpuaddress[23:21] == 3'b000) begin
        chip_idx = cpuaddress[20:19] & CHIP_MASK;
        if (boot) begin
          if (cpuaddress[20:12] == 9'd0) selboot = 1'b1;
          else                           chip_en = 1'b1;
        end else if (ovl) begin
          selkick = 1'b1;
        end else begin
          chip_en = 1'b1;
        end
      end
      if (cpuaddress[23:21] == 3'b110 && cpuaddress[20:19] != 2'b11)
        slow_en = 1'b1;
      if (cpuaddress[23:16] == 8'hdf)
        selreg = 1'b1;
      if (cpuaddress[23:21] == 3'b101) begin
        selciaa = ~cpuaddress[12];
        selciab = ~cpuaddress[13];
      end
`ifdef GARY_IDE_EN
      selide   = (cpuaddress[23:16] == 8'hda);
      selgayle = (cpuaddress[23:16] == 8'hde);
`endif
    end
  end

  always_comb begin
    selchip = '0;
    for (int i = 0; i < CHIP_BANKS; i++)
      selchip[i] = chip_en && (chip_idx == 2'(i));
  end

  // Slow banks at or beyond SLOW_BANKS simply have no select bit.
  always_comb begin
    selslow = '0;
    for (int i = 0; i < SLOW_BANKS; i++)
      selslow[i] = slow_en && (cpuaddress[20:19] == 2'(i));
  end

  always_comb begin
    cia_wait = 1'b0;
    case (state)
      S_IDLE:  cia_wait = acc & cia & ~e;
      S_SYNC:  cia_wait = ~e;
      S_END:   cia_wait = 1'b0;
      default: cia_wait = 1'b0;
    endcase
  end

  assign force_slot = (MAX_STALL > 0) && (stall_cnt == STALL_MAX);

  // CPU handshake: an access (acc=1) completes in the cycle where dbr=0; while dbr=1
  // the CPU holds address and strobes unchanged.
  assign dbr = ~reset_n | dma | cia_wait | (acc & chipreg & dmapri & ~force_slot);
  assign rd  = reset_n & (cpurd  | (dma & ~dmawr));
  assign hwr = reset_n & (cpuhwr | (dma & dmawr));
  assign lwr = reset_n & (cpulwr | (dma & dmawr));

  // END holds the grant until the strobe drops so a second E pulse cannot re-grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (acc && cia && !dma) state <= e ? S_END : S_SYNC;
        S_SYNC: begin
          if (!acc)           state <= S_IDLE;
          else if (e && !dma) state <= S_END;
        end
        S_END:   if (!acc) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      stall_cnt <= '0;
    else if (!dbr || !acc)
      stall_cnt <= '0;
    else if (cck && chipreg && dmapri && !dma && stall_cnt != STALL_MAX)
      stall_cnt <= stall_cnt + 1'b1;
  end

  assign dbg_state = state;
  assign dbg_stall = 8'(stall_cnt);

endmodule

// File: tb/tb_gary_arbiter.sv
// Directed bench for gary_arbiter: drivers queue expected outputs, a negedge monitor compares.
// Main DUT: 4 chip / 2 slow banks, limiter 3; second DUT: 2 chip / 3 slow banks for mirror/slow decode.
module tb_gary_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cck, e;
  logic [11:0] cpuaddress;
  logic [1:0]  dmaaddress;
  logic        cpurd, cpuhwr, cpulwr, dma, dmawr, dmapri, ovl, boot;

  logic       dbr, rd, hwr, lwr, selreg, selciaa, selciab, selkick, selboot, selide, selgayle;
  logic [3:0] selchip;
  logic [1:0] selslow;
  logic [1:0] dbg_state;
  logic [7:0] dbg_stall;

  logic       dbr2, rd2, hwr2, lwr2, selreg2, selciaa2, selciab2, selkick2, selboot2, selide2, selgayle2;
  logic [1:0] selchip2;
  logic [2:0] selslow2;
  logic [1:0] dbg_state2;
  logic [7:0] dbg_stall2;

  gary_arbiter #(.CHIP_BANKS(4), .SLOW_BANKS(2), .MAX_STALL(3)) u_dut (
    .clk(clk), .reset_n(reset_n), .cck(cck), .e(e), .cpuaddress(cpuaddress),
    .dmaaddress(dmaaddress), .cpurd(cpurd), .cpuhwr(cpuhwr), .cpulwr(cpulwr),
    .dma(dma), .dmawr(dmawr), .dmapri(dmapri), .ovl(ovl), .boot(boot),
    .dbr(dbr), .rd(rd), .hwr(hwr), .lwr(lwr), .selchip(selchip), .selslow(selslow),
    .selreg(selreg), .selciaa(selciaa), .selciab(selciab), .selkick(selkick),
    .selboot(selboot), .selide(selide), .selgayle(selgayle),
    .dbg_state(dbg_state), .dbg_stall(dbg_stall)
  );

  gary_arbiter #(.CHIP_BANKS(2), .SLOW_BANKS(3), .MAX_STALL(8)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .cck(cck), .e(e), .cpuaddress(cpuaddress),
    .dmaaddress(dmaaddress), .cpurd(cpurd), .cpuhwr(cpuhwr), .cpulwr(cpulwr),
    .dma(dma), .dmawr(dmawr), .dmapri(dmapri), .ovl(ovl), .boot(boot),
    .dbr(dbr2), .rd(rd2), .hwr(hwr2), .lwr(lwr2), .selchip(selchip2), .selslow(selslow2),
    .selreg(selreg2), .selciaa(selciaa2), .selciab(selciab2), .selkick(selkick2),
    .selboot(selboot2), .selide(selide2), .selgayle(selgayle2),
    .dbg_state(dbg_state2), .dbg_stall(dbg_stall2)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  string       name_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] obs;

  assign obs = {dbr, rd, hwr, lwr, selchip, selslow,
                selreg, selciaa, selciab, selkick, selboot, selide, selgayle,
                selchip2, selslow2, dbg_state, dbg_stall};

  localparam logic [6:0] M_NONE = 7'b0000000;
  localparam logic [6:0] M_REG  = 7'b1000000;
  localparam logic [6:0] M_CIAA = 7'b0100000;
  localparam logic [6:0] M_CIAB = 7'b0010000;
  localparam logic [6:0] M_BOTH = 7'b0110000;
  localparam logic [6:0] M_KICK = 7'b0001000;
  localparam logic [6:0] M_BOOT = 7'b0000100;

  function automatic logic [31:0] mk(input logic d, input logic [2:0] rwl, input logic [3:0] c,
                                     input logic [1:0] s, input logic [6:0] m, input logic [1:0] c2,
                                     input logic [2:0] s2, input logic [1:0] st, input logic [7:0] sc);
    return {d, rwl, c, s, m, c2, s2, st, sc};
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [31:0] x;
      string       nm;
      x  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_cmp++;
      if (obs !== x) begin
        n_err++;
        $display("FAIL %s: got %h expected %h", nm, obs, x);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input string nm, input logic [31:0] x);
    exp_q.push_back(x);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    cck = 0; e = 0; cpuaddress = 12'h000; dmaaddress = 2'b00;
    cpurd = 0; cpuhwr = 0; cpulwr = 0; dma = 0; dmawr = 0; dmapri = 0; ovl = 0; boot = 0;
  endtask

  task automatic report();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
  endtask

  initial begin
    #100000;
    n_err++;
    $display("FAIL watchdog: stimulus did not complete, pending %0d", exp_q.size());
    report();
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 0;
    clear_in();
    cpurd = 1;
    @(posedge clk); #1;
    cyc("reset", mk(1, 3'b000, 4'b0001, 2'b00, M_NONE, 2'b01, 3'b000, 2'd0, 8'd0));
    reset_n = 1;

    // Decode vectors
    ovl = 1; cpuaddress = 12'h000;
    cyc("ovl_kick", mk(0, 3'b100, 4'b0000, 2'b00, M_KICK, 2'b00, 3'b000, 2'd0, 8'd0));
    ovl = 0;
    cyc("chip_b0", mk(0, 3'b100, 4'b0001, 2'b00, M_NONE, 2'b01, 3'b000, 2'd0, 8'd0));
    cpuaddress = 12'h180;
    cyc("chip_b3", mk(0, 3'b100, 4'b1000, 2'b00, M_NONE, 2'b10, 3'b000, 2'd0, 8'd0));
    cpuaddress = 12'h100;
    cyc("chip_mirror", mk(0, 3'b100, 4'b0100, 2'b00, M_NONE, 2'b01, 3'b000, 2'd0, 8'd0));
    boot = 1; cpuaddress = 12'h000;
    cyc("boot_rom", mk(0, 3'b100, 4'b0000, 2'b00, M_BOOT, 2'b00, 3'b000, 2'd0, 8'd0));
    cpuaddress = 12'h080;
    cyc("boot_chip", mk(0, 3'b100, 4'b0010, 2'b00, M_NONE, 2'b10, 3'b000, 2'd0, 8'd0));
    boot = 0; cpuaddress = 12'hf80;
    cyc("kick_rom", mk(0, 3'b100, 4'b0000, 2'b00, M_KICK, 2'b00, 3'b000, 2'd0, 8'd0));
    cpuaddress = 12'hc00;
    cyc("slow_b0", mk(0, 3'b100, 4'b0000, 2'b01, M_NONE, 2'b00, 3'b001, 2'd0, 8'd0));
    cpuaddress = 12'hc80;
    cyc("slow_b1", mk(0, 3'b100, 4'b0000, 2'b10, M_NONE, 2'b00, 3'b010, 2'd0, 8'd0));
    cpuaddress = 12'hd00;
    cyc("slow_b2", mk(0, 3'b100, 4'b0000, 2'b00, M_NONE, 2'b00, 3'b100, 2'd0, 8'd0));
    cpuaddress = 12'hdff;
    cyc("custom_reg", mk(0, 3'b100, 4'b0000, 2'b00, M_REG, 2'b00, 3'b000, 2'd0, 8'd0));
    cpuaddress = 12'hda0;
    cyc("ide_off", mk(0, 3'b100, 4'b0000, 2'b00, M_NONE, 2'b00, 3'b000, 2'd0, 8'd0));
    cpurd = 0; cpuaddress = 12'hbfc;
    cyc("cia_both", mk(0, 3'b000, 4'b0000, 2'b00, M_BOTH, 2'b00, 3'b000, 2'd0, 8'd0));
    cpuaddress = 12'hbfe; dma = 1; dmaaddress = 2'b10;
    cyc("dma_rd", mk(1, 3'b100, 4'b0100, 2'b00, M_NONE, 2'b01, 3'b000, 2'd0, 8'd0));
    dmawr = 1; dmaaddress = 2'b11;
    cyc("dma_wr", mk(1, 3'b011, 4'b1000, 2'b00, M_NONE, 2'b10, 3'b000, 2'd0, 8'd0));
    clear_in(); cpuhwr = 1;
    cyc("cpu_hwr", mk(0, 3'b010, 4'b0001, 2'b00, M_NONE, 2'b01, 3'b000, 2'd0, 8'd0));

    // CIA sync: five waits, grant on E, hold through a second E, release on strobe drop
    clear_in(); cpurd = 1; cpuaddress = 12'hbfe;
    cyc("cia_wait0", mk(1, 3'b100, 4'b0000, 2'b00, M_CIAA, 2'b00, 3'b000, 2'd0, 8'd0));
    for (int i = 1; i < 5; i++)
      cyc("cia_wait", mk(1, 3'b100, 4'b0000, 2'b00, M_CIAA, 2'b00, 3'b000, 2'd1, 8'd0));
    e = 1;
    cyc("cia_grant", mk(0, 3'b100, 4'b0000, 2'b00, M_CIAA, 2'b00, 3'b000, 2'd1, 8'd0));
    e = 0;
    cyc("cia_hold", mk(0, 3'b100, 4'b0000, 2'b00, M_CIAA, 2'b00, 3'b000, 2'd2, 8'd0));
    e = 1;
    cyc("cia_e2_ignored", mk(0, 3'b100, 4'b0000, 2'b00, M_CIAA, 2'b00, 3'b000, 2'd2, 8'd0));
    e = 0; cpurd = 0;
    cyc("cia_release", mk(0, 3'b000, 4'b0000, 2'b00, M_CIAA, 2'b00, 3'b000, 2'd2, 8'd0));
    cyc("cia_idle", mk(0, 3'b000, 4'b0000, 2'b00, M_CIAA, 2'b00, 3'b000, 2'd0, 8'd0));

    // CIA wait where E coincides with DMA: no grant until the next E without DMA
    cpurd = 1; cpuaddress = 12'hbfd;
    cyc("ciab_wait", mk(1, 3'b100, 4'b0000, 2'b00, M_CIAB, 2'b00, 3'b000, 2'd0, 8'd0));
    e = 1; dma = 1; dmaaddress = 2'b00;
    cyc("ciab_e_dma", mk(1, 3'b100, 4'b0001, 2'b00, M_NONE, 2'b01, 3'b000, 2'd1, 8'd0));
    e = 0; dma = 0;
    cyc("ciab_still", mk(1, 3'b100, 4'b0000, 2'b00, M_CIAB, 2'b00, 3'b000, 2'd1, 8'd0));
    e = 1;
    cyc("ciab_grant", mk(0, 3'b100, 4'b0000, 2'b00, M_CIAB, 2'b00, 3'b000, 2'd1, 8'd0));
    e = 0; cpurd = 0;
    cyc("ciab_release", mk(0, 3'b000, 4'b0000, 2'b00, M_CIAB, 2'b00, 3'b000, 2'd2, 8'd0));

    // Starvation limiter (limit 3), with one DMA cycle that must not count
    clear_in(); cck = 1; dmapri = 1; cpurd = 1; cpuaddress = 12'h010;
    cyc("stall_0", mk(1, 3'b100, 4'b0001, 2'b00, M_NONE, 2'b01, 3'b000, 2'd0, 8'd0));
    dma = 1;
    cyc("stall_dma", mk(1, 3'b100, 4'b0001, 2'b00, M_NONE, 2'b01, 3'b000, 2'd0, 8'd1));
    dma = 0;
    cyc("stall_1", mk(1, 3'b100, 4'b0001, 2'b00, M_NONE, 2'b01, 3'b000, 2'd0, 8'd1));
    cyc("stall_2", mk(1, 3'b100, 4'b0001, 2'b00, M_NONE, 2'b01, 3'b000, 2'd0, 8'd2));
    cyc("stall_force", mk(0, 3'b100, 4'b0001, 2'b00, M_NONE, 2'b01, 3'b000, 2'd0, 8'd3));
    cyc("stall_clr", mk(1, 3'b100, 4'b0001, 2'b00, M_NONE, 2'b01, 3'b000, 2'd0, 8'd0));
    cpurd = 0;
    cyc("stall_acc_fall", mk(0, 3'b000, 4'b0001, 2'b00, M_NONE, 2'b01, 3'b000, 2'd0, 8'd1));
    cyc("stall_zero", mk(0, 3'b000, 4'b0001, 2'b00, M_NONE, 2'b01, 3'b000, 2'd0, 8'd0));

    // Reset during SYNC, then re-entry with the strobe still held
    clear_in(); cpurd = 1; cpuaddress = 12'hbfe;
    cyc("rst_wait0", mk(1, 3'b100, 4'b0000, 2'b00, M_CIAA, 2'b00, 3'b000, 2'd0, 8'd0));
    cyc("rst_sync", mk(1, 3'b100, 4'b0000, 2'b00, M_CIAA, 2'b00, 3'b000, 2'd1, 8'd0));
    reset_n = 0;
    cyc("rst_mid", mk(1, 3'b000, 4'b0000, 2'b00, M_CIAA, 2'b00, 3'b000, 2'd0, 8'd0));
    reset_n = 1;
    cyc("rst_rel", mk(1, 3'b100, 4'b0000, 2'b00, M_CIAA, 2'b00, 3'b000, 2'd0, 8'd0));
    cyc("rst_resync", mk(1, 3'b100, 4'b0000, 2'b00, M_CIAA, 2'b00, 3'b000, 2'd1, 8'd0));
    e = 1;
    cyc("rst_grant", mk(0, 3'b100, 4'b0000, 2'b00, M_CIAA, 2'b00, 3'b000, 2'd1, 8'd0));
    clear_in();

    // ---------------- final report ----------------
    @(negedge clk); #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    report();
    $finish;
  end

endmodule
